fu_complete_arbiter: RTL and testbench
======================================

Name: fu_complete_arbiter

Overview:
- Sits directly downstream of the functional units (ALU, mult, branch, load), between FU completion and the CDB/complete stage.
- Each FU emits one FU_COMPLETE_PACKET per cycle and cannot be stalled once started; the pipelined multiplier in particular has NUM_STAGE ops in flight.
- This block buffers completions in per-FU FIFOs and drains up to CDB_WIDTH packets per cycle onto the CDB, using round-robin priority.
- It returns a stall signal to the issue stage so that no FU ever overflows its FIFO.

Parameters:
- NUM_FU, 4, number of FU completion channels.
- CDB_WIDTH, 2, packets broadcast per cycle (1..NUM_FU).
- FIFO_DEPTH, 8, entries per channel FIFO (power of 2, ≥ STALL_MARGIN+1).
- STALL_MARGIN, 5, free entries that must be reserved for in-flight ops (≥ mult NUM_STAGE+1).

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- squash, input, 1, mispredict flush; synchronous.
- fu_complete_in, input, [NUM_FU] FU_COMPLETE_PACKET, per-FU completion; .valid qualifies.
- fu_stall_out, input→output, [NUM_FU], per-FU issue stall to issue stage.
- cdb_out, output, [CDB_WIDTH] FU_COMPLETE_PACKET, broadcast packets; .valid qualifies.
- fifo_count_out, output, [NUM_FU][$clog2(FIFO_DEPTH):0], per-channel occupancy (debug/verification).
- overflow_err, output, 1, sticky; set on a write to a full FIFO.

Behaviour:
- Clocking: one clock, `clock`; `reset` is synchronous and active-high. All state updates on posedge clock with `SD.
- Reset: all FIFOs empty (head/tail/count = 0), rr_ptr = 0, overflow_err = 0.
  - Resulting outputs: cdb_out all-zero with valid = 0; fu_stall_out = 0; fifo_count_out = 0.
- Squash (when not in reset): same clearing as reset, except overflow_err is kept.
  - Inputs presented in the squash cycle are discarded.
  - cdb_out valid is forced to 0 during the squash cycle, and no pops occur.
- Write: if fu_complete_in[i].valid and not reset/squash, the packet is written at tail[i] at the clock edge.
  - tail advances modulo FIFO_DEPTH (natural wrap).
  - Invalid packets are never written.
- Overflow: a write to channel i when count[i]==FIFO_DEPTH and channel i is not popped that cycle drops the packet and sets overflow_err.
  - Write + pop on a full FIFO in the same cycle is legal: the write is accepted and count is unchanged.
- Drain (combinational from registered state):
  - Scan channels starting at rr_ptr, ascending, wrapping mod NUM_FU.
  - Grant the first CDB_WIDTH channels with count>0.
  - The k-th grant drives cdb_out[k] = head packet of that channel, valid=1.
  - Unused slots: all-zero, valid=0.
  - Max one pop per channel per cycle; granted channels pop at the edge.
- rr_ptr update: (last granted channel + 1) mod NUM_FU; unchanged if no grant.
- Latency: a packet written at edge t can appear on cdb_out in the cycle after edge t (1 cycle minimum). A packet written to an empty FIFO is never bypassed in the same cycle.
- Ordering: FIFO order within a channel. No ordering guarantee across channels.
- fu_stall_out[i] = (count[i] ≥ FIFO_DEPTH − STALL_MARGIN). It is derived from registered count only, with no combinational path from inputs.
- Packet contents (dest_value, pr_idx, rob_idx, etc.) pass through unmodified; only .valid is controlled by this block.
- Implementation: packed arrays per channel, generate-free scan loop in always_comb.

Test Plan:
- Reset/idle: assert reset 2 cycles with all inputs valid → cdb_out all valid=0, counts 0, stall 0, overflow_err 0.
- Single path: FU2 valid packet rob_idx=5, dest_value=0x1234 at cycle t → cdb_out[0] carries rob_idx 5 / 0x1234 valid in cycle t+1; cdb_out[1].valid=0; count returns to 0.
- Round-robin: all 4 FUs valid for 1 cycle, rr_ptr=0 → next cycle grants FU0,FU1; cycle after grants FU2,FU3; rr_ptr ends at 0.
- Backpressure: FU1 valid every cycle with CDB slots consumed by lower-priority channels held full → count reaches 3 and fu_stall_out[1]=1. Then 5 more in-flight writes reach 8 with no overflow_err; a 9th write with no pop sets overflow_err=1 and count stays 8.
- Full + simultaneous pop: FIFO0 full, write and grant in same cycle → count stays 8, overflow_err stays 0, FIFO order preserved across tail wrap (rob_idx 0..15 emerge in order).
- Squash mid-drain: 3 channels holding 2, 5, 8 entries, squash for 1 cycle with new valid inputs → that cycle cdb_out valid=0; next cycle all counts 0, stall 0, inputs from squash cycle never appear.

Source files
------------

// File: rtl/fu_complete_arbiter.sv
// Completion arbiter: buffers per-FU completion packets in small FIFOs and drains
// up to CDB_WIDTH of them per cycle onto the CDB in round-robin channel order.
package fu_complete_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] dest_value;
    logic [6:0]  pr_idx;
    logic [4:0]  rob_idx;
  } fu_packet_t;
endpackage

module fu_complete_arbiter
  import fu_complete_pkg::*;
#(
  parameter int NUM_FU       = 4,
  parameter int CDB_WIDTH    = 2,
  parameter int FIFO_DEPTH   = 8,
  parameter int STALL_MARGIN = 5
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    squash,
  input  fu_packet_t [NUM_FU-1:0]                 fu_complete_in,
  output logic [NUM_FU-1:0]                       fu_stall_out,
  output fu_packet_t [CDB_WIDTH-1:0]              cdb_out,
  output logic [NUM_FU-1:0][$clog2(FIFO_DEPTH):0] fifo_count_out,
  output logic                                    overflow_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  fu_packet_t                  mem [NUM_FU][FIFO_DEPTH];
  logic [PTR_W-1:0]            head [NUM_FU];
  logic [PTR_W-1:0]            tail [NUM_FU];
  logic [NUM_FU-1:0][CNT_W-1:0] count;
  logic [FU_W-1:0]             rr_ptr;
  logic [FU_W-1:0]             rr_next;
  logic [FU_W-1:0]             last_grant;
  logic                        any_grant;
  logic [NUM_FU-1:0]           pop;
  logic [NUM_FU-1:0]           wr_en;
  logic [NUM_FU-1:0]           drop;
  logic                        arb_en;

  // Reset and squash both freeze the datapath: no grants, no pops, no writes.
  assign arb_en = !reset && !squash;

  // Round-robin scan from rr_ptr; the k-th non-empty channel found feeds slot k.
  always_comb begin
    logic [FU_W:0]   sum;
    logic [FU_W-1:0] ch;
    int              n_grant;
    cdb_out    = '0;
    pop        = '0;
    any_grant  = 1'b0;
    last_grant = rr_ptr;
    n_grant    = 0;
    sum        = '0;
    ch         = '0;
    for (int s = 0; s < NUM_FU; s++) begin
      sum = {1'b0, rr_ptr} + (FU_W+1)'(s);
      if (sum >= (FU_W+1)'(NUM_FU)) sum = sum - (FU_W+1)'(NUM_FU);
      ch = sum[FU_W-1:0];
      if (arb_en && (count[ch] != '0) && (n_grant < CDB_WIDTH)) begin
        for (int k = 0; k < CDB_WIDTH; k++) begin
          if (n_grant == k) begin
            cdb_out[k]       = mem[ch][head[ch]];
            cdb_out[k].valid = 1'b1;
          end
        end
        pop[ch]    = 1'b1;
        any_grant  = 1'b1;
        last_grant = ch;
        n_grant    = n_grant + 1;
      end
    end
  end

  assign rr_next = (last_grant == FU_W'(NUM_FU-1)) ? '0 : last_grant + 1'b1;

  // A full channel still accepts a write when it is popped in the same cycle.
  always_comb begin
    wr_en = '0;
    drop  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (arb_en && fu_complete_in[i].valid) begin
        if ((count[i] != CNT_W'(FIFO_DEPTH)) || pop[i]) wr_en[i] = 1'b1;
        else                                            drop[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      for (int i = 0; i < NUM_FU; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
      rr_ptr <= '0;
      if (reset) overflow_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (wr_en[i]) tail[i] <= tail[i] + 1'b1;
        if (pop[i])   head[i] <= head[i] + 1'b1;
        count[i] <= count[i] + CNT_W'(wr_en[i]) - CNT_W'(pop[i]);
      end
      if (|drop)     overflow_err <= 1'b1;
      if (any_grant) rr_ptr       <= rr_next;
    end
  end

  // Storage needs no reset: head/tail/count define which entries are live.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (wr_en[i]) mem[i][tail[i]] <= fu_complete_in[i];
    end
  end

  always_comb begin
    fu_stall_out   = '0;
    fifo_count_out = count;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_stall_out[i] = (count[i] >= CNT_W'(FIFO_DEPTH - STALL_MARGIN));
    end
  end

endmodule

// File: tb/tb_fu_complete_arbiter.sv
// Directed bench for fu_complete_arbiter: per-channel expected queues track packet
// order, hand-computed counts/grants check arbitration, stall, overflow and squash.
module tb_fu_complete_arbiter;
  import fu_complete_pkg::*;

  localparam int PKT_W = $bits(fu_packet_t);

  logic                  clock;
  logic                  reset;
  logic                  squash;
  fu_packet_t [3:0]      fu_complete_in;
  logic [3:0]            fu_stall_out;
  fu_packet_t [1:0]      cdb_out;
  logic [3:0][3:0]       fifo_count_out;
  logic                  overflow_err;

  int n_checks = 0;
  int n_errors = 0;
  int seq [4];

  logic [PKT_W-1:0] exp_q0 [$];
  logic [PKT_W-1:0] exp_q1 [$];
  logic [PKT_W-1:0] exp_q2 [$];
  logic [PKT_W-1:0] exp_q3 [$];
  fu_packet_t       obs [2];

  fu_complete_arbiter #(
    .NUM_FU(4), .CDB_WIDTH(2), .FIFO_DEPTH(8), .STALL_MARGIN(5)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .squash         (squash),
    .fu_complete_in (fu_complete_in),
    .fu_stall_out   (fu_stall_out),
    .cdb_out        (cdb_out),
    .fifo_count_out (fifo_count_out),
    .overflow_err   (overflow_err)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic fu_packet_t mk(input int c, input int s);
    fu_packet_t p;
    p            = '0;
    p.valid      = 1'b1;
    p.dest_value = 32'hC0DE_0000 | (32'(c) << 8) | 32'(s);
    p.pr_idx     = {2'(c), 5'(s)};
    p.rob_idx    = 5'(s);
    return p;
  endfunction

  // scoreboard
  task automatic sb_push(input int c, input fu_packet_t p);
    case (c)
      0: exp_q0.push_back(p);
      1: exp_q1.push_back(p);
      2: exp_q2.push_back(p);
      default: exp_q3.push_back(p);
    endcase
  endtask

  task automatic sb_pop(input int c, output logic [PKT_W-1:0] v, output bit ok);
    ok = 1'b0;
    v  = '0;
    case (c)
      0: if (exp_q0.size() > 0) begin v = exp_q0.pop_front(); ok = 1'b1; end
      1: if (exp_q1.size() > 0) begin v = exp_q1.pop_front(); ok = 1'b1; end
      2: if (exp_q2.size() > 0) begin v = exp_q2.pop_front(); ok = 1'b1; end
      default: if (exp_q3.size() > 0) begin v = exp_q3.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic sb_check();
    logic [PKT_W-1:0] e;
    bit               ok;
    for (int k = 0; k < 2; k++) begin
      obs[k] = cdb_out[k];
      if (cdb_out[k].valid) begin
        sb_pop(int'(cdb_out[k].pr_idx[6:5]), e, ok);
        if (!ok) check_eq("sb_extra", 64'(cdb_out[k]), 64'(0));
        else     check_eq("sb_order", 64'(cdb_out[k]), 64'(e));
      end
    end
  endtask

  // driver: called just after a negedge, returns just after the next negedge
  task automatic drive(input logic [3:0] vmask, input logic [3:0] keep, input logic sq);
    fu_packet_t p [4];
    squash = sq;
    for (int c = 0; c < 4; c++) begin
      if (vmask[c]) begin
        p[c] = mk(c, seq[c]);
        seq[c]++;
      end else begin
        p[c] = '0;
      end
      fu_complete_in[c] = p[c];
    end
    #1;
    sb_check();
    if (sq) begin
      exp_q0.delete(); exp_q1.delete(); exp_q2.delete(); exp_q3.delete();
    end else begin
      for (int c = 0; c < 4; c++) if (vmask[c] && keep[c]) sb_push(c, p[c]);
    end
    @(posedge clock);
    @(negedge clock);
    squash         = 1'b0;
    fu_complete_in = '0;
  endtask

  function automatic int q_total();
    return exp_q0.size() + exp_q1.size() + exp_q2.size() + exp_q3.size();
  endfunction

  initial begin
    fu_packet_t sp;
    for (int c = 0; c < 4; c++) seq[c] = 0;

    // reset with all inputs valid
    reset  = 1'b1;
    squash = 1'b0;
    for (int c = 0; c < 4; c++) fu_complete_in[c] = mk(c, 31);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_cdb0_valid", 64'(cdb_out[0].valid), 64'(0));
    check_eq("rst_cdb1_valid", 64'(cdb_out[1].valid), 64'(0));
    check_eq("rst_count", 64'(fifo_count_out), 64'(0));
    check_eq("rst_stall", 64'(fu_stall_out), 64'(0));
    check_eq("rst_ovf", 64'(overflow_err), 64'(0));
    reset          = 1'b0;
    fu_complete_in = '0;

    // single path on FU2
    sp            = '0;
    sp.valid      = 1'b1;
    sp.dest_value = 32'h1234;
    sp.rob_idx    = 5'd5;
    sp.pr_idx     = {2'd2, 5'd5};
    fu_complete_in[2] = sp;
    #1;
    sb_check();
    check_eq("single_no_bypass", 64'(cdb_out[0].valid), 64'(0));
    sb_push(2, sp);
    @(posedge clock);
    @(negedge clock);
    fu_complete_in = '0;
    drive(4'b0000, 4'b0000, 1'b0);
    check_eq("single_valid", 64'(obs[0].valid), 64'(1));
    check_eq("single_rob", 64'(obs[0].rob_idx), 64'(5));
    check_eq("single_data", 64'(obs[0].dest_value), 64'(32'h1234));
    check_eq("single_slot1", 64'(obs[1]), 64'(0));
    check_eq("single_count", 64'(fifo_count_out), 64'(0));

    // move rr_ptr from 3 back to 0
    drive(4'b1000, 4'b1000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    check_eq("rr_wrap_ch", 64'(obs[0].pr_idx[6:5]), 64'(3));

    // round-robin across all four channels
    drive(4'b1111, 4'b1111, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    check_eq("rr1_slot0_ch", 64'(obs[0].pr_idx[6:5]), 64'(0));
    check_eq("rr1_slot1_ch", 64'(obs[1].pr_idx[6:5]), 64'(1));
    drive(4'b0000, 4'b0000, 1'b0);
    check_eq("rr2_slot0_ch", 64'(obs[0].pr_idx[6:5]), 64'(2));
    check_eq("rr2_slot1_ch", 64'(obs[1].pr_idx[6:5]), 64'(3));
    drive(4'b0000, 4'b0000, 1'b0);
    check_eq("rr3_idle", 64'({obs[1].valid, obs[0].valid}), 64'(0));
    check_eq("rr3_count", 64'(fifo_count_out), 64'(0));

    // backpressure: all channels write every cycle, each served every other cycle
    for (int n = 1; n <= 15; n++) begin
      drive(4'b1111, 4'b1111, 1'b0);
      if (n == 4) begin
        check_eq("bp4_count", 64'(fifo_count_out), 64'(16'h3322));
        check_eq("bp4_stall", 64'(fu_stall_out), 64'(4'b1100));
      end
      if (n == 5) begin
        check_eq("bp5_count1", 64'(fifo_count_out[1]), 64'(3));
        check_eq("bp5_stall", 64'(fu_stall_out), 64'(4'b1111));
      end
    end
    check_eq("bp15_count", 64'(fifo_count_out), 64'(16'h8888));
    check_eq("bp15_ovf", 64'(overflow_err), 64'(0));

    // full + simultaneous pop is accepted
    drive(4'b0011, 4'b0011, 1'b0);
    check_eq("fullpop_count", 64'(fifo_count_out), 64'(16'h8888));
    check_eq("fullpop_ovf", 64'(overflow_err), 64'(0));
    drive(4'b0100, 4'b0100, 1'b0);
    check_eq("fullpop2_count", 64'(fifo_count_out), 64'(16'h7888));
    drive(4'b0010, 4'b0010, 1'b0);
    check_eq("fullpop3_count", 64'(fifo_count_out), 64'(16'h7887));
    check_eq("fullpop3_ovf", 64'(overflow_err), 64'(0));

    // write to a full, un-popped channel is dropped
    drive(4'b0010, 4'b0000, 1'b0);
    check_eq("ovf_count", 64'(fifo_count_out), 64'(16'h6787));
    check_eq("ovf_set", 64'(overflow_err), 64'(1));

    // drain; scoreboard checks order across tail wrap
    for (int d = 1; d <= 16; d++) begin
      drive(4'b0000, 4'b0000, 1'b0);
      if (d == 14) begin
        check_eq("drain14_slot0_ch", 64'(obs[0].pr_idx[6:5]), 64'(2));
        check_eq("drain14_slot1_ch", 64'(obs[1].pr_idx[6:5]), 64'(1));
      end
    end
    check_eq("drain_count", 64'(fifo_count_out), 64'(0));
    check_eq("drain_all_seen", 64'(q_total()), 64'(0));
    check_eq("drain_ovf_sticky", 64'(overflow_err), 64'(1));

    // squash mid-drain
    for (int n = 1; n <= 4; n++) drive(4'b1111, 4'b1111, 1'b0);
    check_eq("presq_count", 64'(fifo_count_out), 64'(16'h2233));
    check_eq("presq_stall", 64'(fu_stall_out), 64'(4'b0011));
    drive(4'b1111, 4'b1111, 1'b1);
    check_eq("sq_cdb_valid", 64'({obs[1].valid, obs[0].valid}), 64'(0));
    check_eq("sq_count", 64'(fifo_count_out), 64'(0));
    check_eq("sq_stall", 64'(fu_stall_out), 64'(0));
    check_eq("sq_ovf_kept", 64'(overflow_err), 64'(1));
    drive(4'b0000, 4'b0000, 1'b0);
    check_eq("postsq_idle1", 64'({obs[1].valid, obs[0].valid}), 64'(0));
    drive(4'b0000, 4'b0000, 1'b0);
    check_eq("postsq_idle2", 64'({obs[1].valid, obs[0].valid}), 64'(0));

    // normal traffic resumes after squash
    drive(4'b0001, 4'b0001, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    check_eq("resume_valid", 64'(obs[0].valid), 64'(1));
    check_eq("end_count", 64'(fifo_count_out), 64'(0));
    check_eq("end_all_seen", 64'(q_total()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
